orv32_csr_file: RTL and testbench



---
 rtl/orv32_csr_file.sv | 194 +++++++++++++++++++
 tb/tb_orv32_csr_file.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/orv32_csr_file.sv
// Machine-mode CSR file for ORV32: CSR decode/read/write, trap and mret state; counters built only with ORV32_CSR_COUNTERS_EN.
// Latency: reads are combinational; writes, trap and mret updates are visible the cycle after the edge.
// Backpressure: none; an access is accepted every cycle it is presented.
module orv32_csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_valid_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mstatus_mie_o,
  output logic [1:0]  priv_lvl_o
);

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  csr_op_e     op;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [30:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_val, minstret_val;
  logic [31:0] csr_old, csr_wval;
  logic        addr_known, addr_ro, csr_illegal, csr_wr;
  logic        unused_trap_pc0;

  assign op = csr_op_e'(csr_op_i);
  // mepc is always even, so the faulting PC's bit 0 is never stored.
  assign unused_trap_pc0 = trap_pc_i[0];

  always_comb begin
    csr_old    = 32'h0;
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr_i)
      A_MHARTID:   begin csr_old = HART_ID; addr_ro = 1'b1; end
      A_MSTATUS:   csr_old = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      A_MISA:      begin csr_old = MISA_VAL; addr_ro = 1'b1; end
      A_MTVEC:     csr_old = {mtvec_q, 2'b00};
      A_MSCRATCH:  csr_old = mscratch_q;
      A_MEPC:      csr_old = {mepc_q, 1'b0};
      A_MCAUSE:    csr_old = mcause_q;
      A_MTVAL:     csr_old = mtval_q;
      A_MCYCLE:    csr_old = mcycle_val[31:0];
      A_MCYCLEH:   csr_old = mcycle_val[63:32];
      A_MINSTRET:  csr_old = minstret_val[31:0];
      A_MINSTRETH: csr_old = minstret_val[63:32];
      A_CYCLE:     begin csr_old = mcycle_val[31:0]; addr_ro = 1'b1; end
      default:     addr_known = 1'b0;
    endcase
  end

  assign csr_illegal   = csr_valid_i & (~addr_known | ((op != OP_READ) & addr_ro));
  assign csr_wr        = csr_valid_i & ~csr_illegal & (op != OP_READ);
  assign csr_illegal_o = csr_illegal;
  assign csr_rdata_o   = csr_illegal ? 32'h0 : csr_old;

  always_comb begin
    csr_wval = csr_old;
    case (op)
      OP_WRITE: csr_wval = csr_wdata_i;
      OP_SET:   csr_wval = csr_old | csr_wdata_i;
      OP_CLEAR: csr_wval = csr_old & ~csr_wdata_i;
      default:  csr_wval = csr_old;
    endcase
  end

  // Later assignments override earlier ones: trap beats mret beats CSR write.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (csr_wr) begin
      case (csr_addr_i)
        A_MSTATUS:  begin mie_d = csr_wval[3]; mpie_d = csr_wval[7]; end
        A_MTVEC:    mtvec_d    = csr_wval[31:2];
        A_MSCRATCH: mscratch_d = csr_wval;
        A_MEPC:     mepc_d     = csr_wval[31:1];
        A_MCAUSE:   mcause_d   = csr_wval;
        A_MTVAL:    mtval_d    = csr_wval;
        default:    ;
      endcase
    end
    if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (trap_i) begin
      mepc_d   = trap_pc_i[31:1];
      mcause_d = trap_cause_i;
      mtval_d  = trap_tval_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= 32'h0;
      mepc_q     <= 31'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef ORV32_CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  // A written word takes the written value; a low-word write also swallows that cycle's carry.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret_i};
    if (csr_wr && csr_addr_i == A_MCYCLE)    mcycle_d         = {mcycle_q[63:32], csr_wval};
    if (csr_wr && csr_addr_i == A_MCYCLEH)   mcycle_d[63:32]  = csr_wval;
    if (csr_wr && csr_addr_i == A_MINSTRET)  minstret_d       = {minstret_q[63:32], csr_wval};
    if (csr_wr && csr_addr_i == A_MINSTRETH) minstret_d[63:32] = csr_wval;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_val   = mcycle_q;
  assign minstret_val = minstret_q;
`else
  logic unused_instret;

  assign unused_instret = instret_i;
  assign mcycle_val     = 64'h0;
  assign minstret_val   = 64'h0;
`endif

  assign mtvec_o       = {mtvec_q, 2'b00};
  assign mepc_o        = {mepc_q, 1'b0};
  assign mstatus_mie_o = mie_q;
  assign priv_lvl_o    = 2'b11;

endmodule

// File: tb/tb_orv32_csr_file.sv
// Randomized scoreboard bench for orv32_csr_file against a spec-level CSR model.
`timescale 1ns/1ps
module tb_orv32_csr_file;

  localparam logic [31:0] P_HART_ID   = 32'h0000_0003;
  localparam logic [31:0] P_MISA      = 32'h4000_0100;
  localparam logic [31:0] P_MTVEC_RST = 32'h8000_0103;
`ifdef ORV32_CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        csr_valid_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i, csr_rdata_o;
  logic        csr_illegal_o, instret_i, trap_i, mret_i, mstatus_mie_o;
  logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i, mtvec_o, mepc_o;
  logic [1:0]  priv_lvl_o;

  orv32_csr_file #(
    .HART_ID(P_HART_ID), .MISA_VAL(P_MISA), .MTVEC_RESET(P_MTVEC_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .instret_i(instret_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_mie_o(mstatus_mie_o),
    .priv_lvl_o(priv_lvl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state as the programmer sees it.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [1:0] R = 2'd0, W = 2'd1, S = 2'd2, C = 2'd3;

  function automatic void model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = P_MTVEC_RST & ~32'h3;
    m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
    m_cycle = 64'h0; m_instret = 64'h0;
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    return a inside {12'hF14, 12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00};
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a inside {12'hF14, 12'h301, 12'hC00};
  endfunction

  function automatic logic [31:0] m_val(input logic [11:0] a);
    case (a)
      12'hF14: return P_HART_ID;
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: return P_MISA;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(input logic v, input logic [1:0] op, input logic [11:0] a,
                                     input logic [31:0] wd, input logic inst, input logic tr,
                                     input logic [31:0] cause, input logic [31:0] pc,
                                     input logic [31:0] tval, input logic mr);
    logic [31:0] old, nv;
    logic [63:0] n_cyc, n_ins;
    bit wr;
    old = m_val(a);
    wr  = v && (op != R) && m_known(a) && !m_ro(a);
    nv  = (op == W) ? wd : (op == S) ? (old | wd) : (old & ~wd);
    n_cyc = m_cycle + 64'd1;
    n_ins = m_instret + 64'(inst);
    if (wr) begin
      case (a)
        12'h300: if (!tr && !mr) begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: if (!tr) m_mepc = nv & ~32'h1;
        12'h342: if (!tr) m_mcause = nv;
        12'h343: if (!tr) m_mtval = nv;
        12'hB00: n_cyc = {m_cycle[63:32], nv};
        12'hB80: n_cyc = {nv, n_cyc[31:0]};
        12'hB02: n_ins = {m_instret[63:32], nv};
        12'hB82: n_ins = {nv, n_ins[31:0]};
        default: ;
      endcase
    end
    if (tr) begin
      m_mepc = pc & ~32'h1; m_mcause = cause; m_mtval = tval;
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (mr) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end
    if (CNT_EN) begin
      m_cycle = n_cyc;
      m_instret = n_ins;
    end
  endfunction

  task automatic check(input string name, input logic [11:0] a, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s addr=%03h got=%08h expected=%08h at %0t", name, a, act, exp, $time);
  endtask

  // Monitor: every presented access is matched against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (csr_valid_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty addr=%03h got=access expected=none", csr_addr_i);
      end else begin
        e = exp_q.pop_front();
        check("rdata",   e.addr, csr_rdata_o, e.rdata);
        check("illegal", e.addr, {31'd0, csr_illegal_o}, {31'd0, e.illegal});
        check("mtvec_o", e.addr, mtvec_o, e.mtvec);
        check("mepc_o",  e.addr, mepc_o, e.mepc);
        check("mie_o",   e.addr, {31'd0, mstatus_mie_o}, {31'd0, e.mie});
        check("priv",    e.addr, {30'd0, priv_lvl_o}, 32'd3);
      end
    end
  end

  // Starts at posedge+1 (or later mid-cycle), returns at the next posedge+1.
  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic inst, input logic tr,
                       input logic [31:0] cause, input logic [31:0] pc,
                       input logic [31:0] tval, input logic mr);
    exp_t e;
    bit ill;
    csr_valid_i = v; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
    instret_i = inst; trap_i = tr; trap_cause_i = cause; trap_pc_i = pc;
    trap_tval_i = tval; mret_i = mr;
    ill = !m_known(a) || (op != R && m_ro(a));
    e.addr = a; e.rdata = ill ? 32'h0 : m_val(a); e.illegal = ill;
    e.mtvec = m_mtvec; e.mepc = m_mepc; e.mie = m_mie;
    if (v) exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, op, a, wd, inst, tr, cause, pc, tval, mr);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    drive(1'b1, op, a, wd, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [11:0] pick_addr(input int unsigned i);
    case (i)
      0: return 12'hF14;  1: return 12'h300;  2: return 12'h301;  3: return 12'h305;
      4: return 12'h340;  5: return 12'h341;  6: return 12'h342;  7: return 12'h343;
      8: return 12'hB00;  9: return 12'hB80; 10: return 12'hB02; 11: return 12'hB82;
      12: return 12'hC00; 13: return 12'h7C0;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; csr_valid_i = 1'b0; csr_op_i = R; csr_addr_i = 12'h0; csr_wdata_i = 32'h0;
    instret_i = 1'b0; trap_i = 1'b0; trap_cause_i = 32'h0; trap_pc_i = 32'h0;
    trap_tval_i = 32'h0; mret_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    csr(R, 12'h300, 0); csr(R, 12'h305, 0); csr(R, 12'h341, 0);
    csr(R, 12'hF14, 0); csr(R, 12'h301, 0);

    csr(S, 12'h300, 32'h8); csr(R, 12'h300, 0);
    csr(C, 12'h300, 32'h8); csr(R, 12'h300, 0);
    csr(W, 12'h300, 32'hFFFF_FFFF); csr(R, 12'h300, 0);

    csr(W, 12'h300, 32'h8);
    drive(1'b0, R, 12'h0, 0, 1'b0, 1'b1, 32'h8000_000B, 32'h100, 32'h55, 1'b0);
    csr(R, 12'h341, 0); csr(R, 12'h342, 0); csr(R, 12'h343, 0); csr(R, 12'h300, 0);
    drive(1'b0, R, 12'h0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    csr(R, 12'h300, 0);

    drive(1'b1, W, 12'h341, 32'h200, 1'b0, 1'b1, 32'h2, 32'h300, 32'h0, 1'b0);
    csr(R, 12'h341, 0);
    drive(1'b1, W, 12'h340, 32'h1234, 1'b0, 1'b1, 32'h3, 32'h405, 32'h9, 1'b0);
    csr(R, 12'h340, 0); csr(R, 12'h341, 0); csr(R, 12'h300, 0);
    drive(1'b1, W, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    csr(R, 12'h300, 0);

    csr(W, 12'h305, 32'hFFFF_FFFF); csr(R, 12'h305, 0);
    csr(W, 12'h341, 32'hFFFF_FFFF); csr(R, 12'h341, 0);

    csr(W, 12'hB00, 32'hFFFF_FFFE); csr(W, 12'hB80, 32'h0);
    csr(R, 12'hB80, 0); csr(R, 12'hB00, 0); csr(R, 12'hC00, 0); csr(R, 12'hB80, 0);
    csr(W, 12'hB02, 32'h0); csr(W, 12'hB82, 32'h0);
    drive(1'b1, R, 12'hB02, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, R, 12'hB02, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    csr(R, 12'hB02, 0);
    drive(1'b1, W, 12'hB02, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, R, 12'hB02, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    csr(R, 12'hB02, 0); csr(R, 12'hB82, 0);

    csr(W, 12'h301, 32'h123); csr(R, 12'h301, 0); csr(R, 12'h7C0, 0);
    csr(W, 12'h7C0, 32'h5); csr(S, 12'hF14, 32'h0); csr(W, 12'hC00, 32'h5);
    csr(C, 12'h301, 32'hFFFF_FFFF); csr(R, 12'h301, 0); csr(R, 12'h340, 0);

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    csr(W, 12'h340, 32'hCAFE); csr(W, 12'h300, 32'h8);
    #2 rst_n = 1'b0;
    model_reset();
    drive(1'b1, R, 12'h300, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, R, 12'h340, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    csr(R, 12'h340, 0); csr(R, 12'h305, 0); csr(R, 12'hB00, 0); csr(R, 12'hB00, 0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(7) != 0), 2'($urandom_range(3)), pick_addr($urandom_range(15)),
            ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom_range(1)),
            ($urandom_range(7) == 0), $urandom, $urandom, $urandom, ($urandom_range(7) == 0));
    end
    csr_valid_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
